// File: rtl/risc_datapath.sv
// VeriRisc datapath: PC, IR, accumulator, ALU, address mux and memory-bus drive,
// plus the 3-bit phase counter that sequences the controller.
module risc_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              rd,
    input  logic              ld_ir,
    input  logic              halt,
    input  logic              inc_pc,
    input  logic              ld_ac,
    input  logic              wr,
    input  logic              ld_pc,
    input  logic              data_e,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [2:0]        opcode,
    output logic              zero,
    output logic [2:0]        phase
);

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_t;

    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_ac;
    logic [2:0]        r_phase;

    logic [2:0]        w_opcode;
    logic [ADDR_W-1:0] w_operand;
    logic [DATA_W-1:0] w_alu;

    assign w_opcode  = r_ir[DATA_W-1:ADDR_W];
    assign w_operand = r_ir[ADDR_W-1:0];

    // The ALU decodes the opcode already held in IR, so a simultaneous
    // ld_ir/ld_ac feeds the accumulator the result for the old instruction.
    always_comb begin
        w_alu = r_ac;
        case (w_opcode)
            OP_ADD:  w_alu = r_ac + mem_data_in;
            OP_AND:  w_alu = r_ac & mem_data_in;
            OP_XOR:  w_alu = r_ac ^ mem_data_in;
            OP_LDA:  w_alu = mem_data_in;
            default: w_alu = r_ac;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc    <= '0;
            r_ir    <= '0;
            r_ac    <= '0;
            r_phase <= '0;
        end else begin
            if (!halt) begin
                r_phase <= r_phase + 3'd1;
            end
            // A jump outranks the sequential increment.
            if (ld_pc) begin
                r_pc <= w_operand;
            end else if (inc_pc) begin
                r_pc <= r_pc + ADDR_W'(1);
            end
            if (ld_ir) begin
                r_ir <= mem_data_in;
            end
            if (ld_ac) begin
                r_ac <= w_alu;
            end
        end
    end

    assign mem_addr     = sel ? r_pc : w_operand;
    assign mem_data_out = data_e ? r_ac : '0;
    assign mem_rd       = rd;
    assign mem_wr       = wr;
    assign opcode       = w_opcode;
    assign zero         = (r_ac == '0);
    assign phase        = r_phase;

endmodule

// File: tb/tb_risc_datapath.sv
// Bench for risc_datapath: directed and random cycles scored against an
// arithmetic model of the datapath registers; a monitor compares every cycle.
module tb_risc_datapath;

  localparam int W = 22;

  localparam logic [8:0] S_SEL    = 9'h100;
  localparam logic [8:0] S_RD     = 9'h080;
  localparam logic [8:0] S_LD_IR  = 9'h040;
  localparam logic [8:0] S_HALT   = 9'h020;
  localparam logic [8:0] S_INC_PC = 9'h010;
  localparam logic [8:0] S_LD_AC  = 9'h008;
  localparam logic [8:0] S_WR     = 9'h004;
  localparam logic [8:0] S_LD_PC  = 9'h002;
  localparam logic [8:0] S_DATA_E = 9'h001;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic       sel = 1'b0, rd = 1'b0, ld_ir = 1'b0, halt = 1'b0, inc_pc = 1'b0;
  logic       ld_ac = 1'b0, wr = 1'b0, ld_pc = 1'b0, data_e = 1'b0;
  logic [7:0] mem_data_in = 8'h00;
  logic [4:0] mem_addr;
  logic [7:0] mem_data_out;
  logic       mem_rd, mem_wr, zero;
  logic [2:0] opcode, phase;

  risc_datapath #(.DATA_W(8), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .sel(sel), .rd(rd), .ld_ir(ld_ir), .halt(halt),
    .inc_pc(inc_pc), .ld_ac(ld_ac), .wr(wr), .ld_pc(ld_pc), .data_e(data_e),
    .mem_data_in(mem_data_in), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .opcode(opcode), .zero(zero), .phase(phase)
  );

  // reference model state
  int m_pc = 0, m_ir = 0, m_ac = 0, m_phase = 0;
  bit check_en = 1'b0;
  int cyc_n = 0;

  logic [W-1:0] exp_q[$];
  int           tag_q[$];
  int           total = 0;
  int           bad = 0;

  function automatic int alu(input int op, input int a, input int b);
    case (op)
      2: return (a + b) % 256;
      3: return a & b;
      4: return a ^ b;
      5: return b;
      default: return a;
    endcase
  endfunction

  // driver: apply one cycle of inputs, log expected outputs, advance the model
  task automatic cyc(input logic r, input logic [8:0] s, input logic [7:0] din);
    logic [4:0] e_addr;
    logic [7:0] e_dout;
    logic [2:0] e_op, e_ph;
    logic       e_zero;
    int         n_pc, n_ac;
    @(negedge clk);
    rst = r;
    sel = s[8]; rd = s[7]; ld_ir = s[6]; halt = s[5]; inc_pc = s[4];
    ld_ac = s[3]; wr = s[2]; ld_pc = s[1]; data_e = s[0];
    mem_data_in = din;
    #1;
    if (check_en) begin
      e_addr = 5'(sel ? m_pc : m_ir % 32);
      e_dout = 8'(data_e ? m_ac : 0);
      e_op   = 3'(m_ir / 32);
      e_zero = (m_ac == 0);
      e_ph   = 3'(m_phase);
      exp_q.push_back({e_addr, e_dout, rd, wr, e_op, e_zero, e_ph});
      tag_q.push_back(cyc_n);
    end
    cyc_n++;
    if (!r) begin
      m_pc = 0; m_ir = 0; m_ac = 0; m_phase = 0;
    end else begin
      n_ac = ld_ac ? alu(m_ir / 32, m_ac, int'(din)) : m_ac;
      n_pc = ld_pc ? m_ir % 32 : (inc_pc ? (m_pc + 1) % 32 : m_pc);
      if (ld_ir) m_ir = int'(din);
      m_ac = n_ac;
      m_pc = n_pc;
      if (!halt) m_phase = (m_phase + 1) % 8;
    end
  endtask

  // load ac with v through an LDA, then leave next_ir in IR
  task automatic set_ac(input logic [7:0] v, input logic [7:0] next_ir);
    cyc(1'b1, S_LD_IR, 8'hA0);
    cyc(1'b1, S_LD_AC, v);
    cyc(1'b1, S_LD_IR, next_ir);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] act, exp_v;
    int tag;
    #3;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      tag = tag_q.pop_front();
      act = {mem_addr, mem_data_out, mem_rd, mem_wr, opcode, zero, phase};
      total++;
      if (act !== exp_v) begin
        bad++;
        $display("FAIL cyc%0d outputs: got addr=%h dout=%h rd=%b wr=%b op=%0d zero=%b ph=%0d, want addr=%h dout=%h rd=%b wr=%b op=%0d zero=%b ph=%0d",
                 tag, act[21:17], act[16:9], act[8], act[7], act[6:4], act[3], act[2:0],
                 exp_v[21:17], exp_v[16:9], exp_v[8], exp_v[7], exp_v[6:4], exp_v[3], exp_v[2:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // reset held two cycles with every strobe high
    cyc(1'b0, 9'h1FF, 8'hFF);
    check_en = 1'b1;
    cyc(1'b0, 9'h1FF, 8'hFF);
    for (int i = 0; i < 9; i++) cyc(1'b1, S_SEL, 8'h00);

    // fetch + LDA
    cyc(1'b1, S_SEL | S_RD | S_LD_IR, 8'hA3);
    cyc(1'b1, S_RD | S_LD_AC, 8'h00);
    cyc(1'b1, S_LD_AC | S_DATA_E, 8'h7F);
    cyc(1'b1, S_DATA_E, 8'h00);

    // ADD with carry discarded, and wrap to zero
    set_ac(8'hF0, 8'h40);
    cyc(1'b1, S_LD_AC, 8'h20);
    cyc(1'b1, S_DATA_E, 8'h00);
    set_ac(8'hF0, 8'h40);
    cyc(1'b1, S_LD_AC, 8'h10);
    cyc(1'b1, S_DATA_E, 8'h00);

    // PC 31 -> 0, then ld_pc beats inc_pc
    cyc(1'b1, S_LD_IR, 8'h1F);
    cyc(1'b1, S_LD_PC, 8'h00);
    cyc(1'b1, S_SEL | S_INC_PC, 8'h00);
    cyc(1'b1, S_SEL, 8'h00);
    cyc(1'b1, S_LD_IR, 8'hE9);
    cyc(1'b1, S_SEL | S_LD_PC | S_INC_PC, 8'h00);
    cyc(1'b1, S_SEL, 8'h00);

    // STO drive with and without data_e
    set_ac(8'h5A, 8'hC4);
    cyc(1'b1, S_WR | S_DATA_E, 8'h00);
    cyc(1'b1, S_WR, 8'h00);

    // simultaneous ld_ir/ld_ac uses the old opcode (ADD)
    set_ac(8'h11, 8'h40);
    cyc(1'b1, S_LD_IR | S_LD_AC, 8'h22);
    cyc(1'b1, S_DATA_E, 8'h00);

    // halt at phase 3 for four cycles
    for (int i = 0; i < 8 && m_phase != 3; i++) cyc(1'b1, 9'h000, 8'h00);
    for (int i = 0; i < 4; i++) cyc(1'b1, S_HALT, 8'h00);
    cyc(1'b1, 9'h000, 8'h00);
    cyc(1'b1, 9'h000, 8'h00);

    // reset mid-run with pc=12, ac=0x33
    cyc(1'b1, S_LD_IR, 8'h0C);
    cyc(1'b1, S_LD_PC, 8'h00);
    set_ac(8'h33, 8'h0C);
    cyc(1'b1, S_SEL | S_DATA_E, 8'h00);
    cyc(1'b0, 9'h1FF, 8'hAA);
    cyc(1'b1, S_SEL | S_DATA_E, 8'h00);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 31) != 0), 9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)));
    end

    @(negedge clk);
    #5;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/risc_datapath.md
Name: risc_datapath

Overview:
- Datapath stage directly downstream of the VeriRisc controller; consumes its nine control strobes.
- Contains the program counter, instruction register, accumulator, ALU, address mux and memory-bus drive.
- Also contains the 3-bit phase counter that sequences the controller.
- Returns opcode, zero flag and phase to the controller; drives the external memory's address, data and read/write.

Parameters:
DATA_W, 8, data/accumulator/instruction width
ADDR_W, 5, memory address width (instruction = {opcode[2:0], addr[ADDR_W-1:0]}, so DATA_W = ADDR_W + 3)

Ports:
clk  input  1  single clock, all state updates on posedge
rst  input  1  synchronous, active-low reset (rst==0 at posedge clk resets)
sel  input  1  address select: 1 = PC, 0 = IR operand field
rd  input  1  memory read strobe from controller
ld_ir  input  1  load IR from mem_data_in
halt  input  1  freeze phase counter
inc_pc  input  1  PC increment
ld_ac  input  1  load accumulator from ALU
wr  input  1  memory write strobe from controller
ld_pc  input  1  load PC from IR operand field
data_e  input  1  enable accumulator onto mem_data_out
mem_data_in  input  DATA_W  memory read data
mem_addr  output  ADDR_W  memory address
mem_data_out  output  DATA_W  memory write data
mem_rd  output  1  memory read enable
mem_wr  output  1  memory write enable
opcode  output  3  IR[DATA_W-1:ADDR_W], to controller
zero  output  1  accumulator == 0, to controller
phase  output  3  current phase 0..7, to controller

Behaviour:
- Reset (rst==0 at posedge): pc=0, ir=0, ac=0, phase=0; therefore opcode=0, zero=1, mem_addr=0 when sel=1. Reset overrides every strobe, including mid-instruction.
- Phase counter:
  - phase+1 mod 8 each cycle while rst=1 and halt=0; 7 wraps to 0.
  - halt=1 holds phase at its current value; counting resumes on the cycle halt drops.
- PC:
  - ld_pc=1: pc <= ir[ADDR_W-1:0].
  - Else inc_pc=1: pc <= pc+1 mod 2^ADDR_W (31 -> 0).
  - Else hold. ld_pc has priority when both are asserted.
- IR: ld_ir=1 loads mem_data_in; else hold.
- Accumulator: ld_ac=1 loads alu_out; else hold.
- ALU (combinational, operand a=ac, b=mem_data_in), selected by opcode:
  - 0 HLT: a
  - 1 SKZ: a
  - 2 ADD: a+b truncated to DATA_W (carry discarded)
  - 3 AND: a&b
  - 4 XOR: a^b
  - 5 LDA: b
  - 6 STO: a
  - 7 JMP: a
- zero = (ac == 0), combinational from the registered ac. It reflects a new ac value the cycle after the ld_ac edge.
- mem_addr = sel ? pc : ir[ADDR_W-1:0] (combinational).
- mem_rd = rd, mem_wr = wr (combinational pass-through, zero latency).
- mem_data_out = data_e ? ac : 0. No tristate.
- Simultaneous ld_ir and ld_ac: both load on the same edge.
  - ALU uses the pre-edge ir opcode.
  - ac gets the result for the old opcode.
- Any strobe combination is legal; no illegal-state handling is required.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with all strobes = 1 -> pc=0, ir=0, ac=0, phase=0, zero=1. After release, phase steps 0,1,...,7,0.
2. Fetch and LDA:
   - sel=1, rd=1, ld_ir=1, mem_data_in=8'hA3 -> ir=8'hA3, opcode=5, mem_addr (sel=0) = 5'h03.
   - Then ld_ac=1, mem_data_in=8'h00 -> ac=0, zero=1.
   - Then mem_data_in=8'h7F with ld_ac -> ac=8'h7F, zero=0.
3. ADD wrap: ac=8'hF0, opcode=2, mem_data_in=8'h20, ld_ac=1 -> ac=8'h10. Same setup with mem_data_in=8'h10 -> ac=0, zero=1.
4. PC boundary:
   - pc=31, inc_pc=1 -> pc=0.
   - ir=8'hE9 with ld_pc=1 and inc_pc=1 on the same edge -> pc=9.
5. STO: ac=8'h5A, ir=8'hC4, sel=0, wr=1, data_e=1 -> mem_addr=4, mem_data_out=8'h5A, mem_wr=1. With data_e=0 -> mem_data_out=0.
6. Halt and reset mid-run:
   - Assert halt at phase=3 for 4 cycles -> phase stays 3, then 4 after release.
   - Drop rst with pc=12, ac=8'h33 -> all registers return to 0 on that edge.
